// File: rtl/can_bit_destuff_pkg.sv
// Shared CAN definitions: frame field constants, the bit-destuffer FSM state
// encoding and the default stuffing run length.
package can_bit_destuff_pkg;

  // A run of this many equal bits is followed by a complementary stuff bit.
  localparam int STUFF_LEN_DEFAULT = 5;

  // CAN frame field sizes
  localparam int ID_STD_W = 11;
  localparam int ID_EXT_W = 29;
  localparam int DLC_W    = 4;
  localparam int CRC_W    = 15;
  localparam int EOF_LEN  = 7;

  // CRC-15 generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STUFF = 2'd2,
    ST_ERR   = 2'd3
  } destuff_state_e;

endpackage

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer.
// Removes the complementary stuff bit that follows every run of STUFF_LEN
// equal bits inside the destuff window and flags a stuff violation when that
// bit is not complementary. Delivered bits feed the downstream CRC stage.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   bit_strobe - one-cycle pulse at the sample point of rx_bit
//   rx_bit     - sampled bus bit (1 = recessive, 0 = dominant)
//   destuff_en - high from SOF through the last CRC bit
//   dout       - destuffed data bit, holds while dout_valid is low
//   dout_valid - one-cycle strobe per delivered bit
//   stuff_drop - one-cycle strobe per removed stuff bit
//   stuff_err  - sticky stuff-violation flag, cleared when destuff_en drops
//   bit_cnt    - saturating count of delivered bits in the current window
module can_bit_destuff
  import can_bit_destuff_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_strobe,
  input  logic             rx_bit,
  input  logic             destuff_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             stuff_drop,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

  destuff_state_e   state;
  logic [RUN_W-1:0] run_len;
  logic             last_bit;
  logic [RUN_W-1:0] run_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Run length after accepting rx_bit in RUN; the guard keeps the counter
  // bounded by STUFF_LEN even though RUN never sees a full run.
  always_comb begin
    run_next = RUN_ONE;
    if ((rx_bit == last_bit) && (run_len != RUN_MAX))
      run_next = run_len + RUN_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      run_len    <= '0;
      last_bit   <= 1'b1;
      dout       <= 1'b1;
      dout_valid <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      dout_valid <= 1'b0;
      stuff_drop <= 1'b0;
      if (!destuff_en) begin
        // Leaving the window (or a strobe in the falling cycle) discards
        // everything about the current frame; dout keeps its last value.
        state     <= ST_IDLE;
        run_len   <= '0;
        last_bit  <= 1'b1;
        stuff_err <= 1'b0;
        bit_cnt   <= '0;
      end else if (bit_strobe) begin
        unique case (state)
          ST_IDLE: begin
            dout       <= rx_bit;
            dout_valid <= 1'b1;
            bit_cnt    <= sat_inc(bit_cnt);
            last_bit   <= rx_bit;
            run_len    <= RUN_ONE;
            state      <= (RUN_ONE == RUN_MAX) ? ST_STUFF : ST_RUN;
          end
          ST_RUN: begin
            dout       <= rx_bit;
            dout_valid <= 1'b1;
            bit_cnt    <= sat_inc(bit_cnt);
            last_bit   <= rx_bit;
            run_len    <= run_next;
            state      <= (run_next == RUN_MAX) ? ST_STUFF : ST_RUN;
          end
          ST_STUFF: begin
            if (rx_bit != last_bit) begin
              // The stuff bit itself opens the next run.
              stuff_drop <= 1'b1;
              last_bit   <= rx_bit;
              run_len    <= RUN_ONE;
              state      <= (RUN_ONE == RUN_MAX) ? ST_STUFF : ST_RUN;
            end else begin
              stuff_err <= 1'b1;
              state     <= ST_ERR;
            end
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Self-checking bench for can_bit_destuff: a window-based reference model of
// CAN destuffing, directed frames with literal expectations, stuffed streams
// produced by an independent bit stuffer, and a randomized soak.
module tb_can_bit_destuff;

  localparam int SL      = 5;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_strobe = 1'b0;
  logic          rx_bit = 1'b1;
  logic          destuff_en = 1'b0;
  logic          dout;
  logic          dout_valid;
  logic          stuff_drop;
  logic          stuff_err;
  logic [CW-1:0] bit_cnt;

  always #5 clk = ~clk;

  can_bit_destuff #(.STUFF_LEN(SL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_strobe (bit_strobe),
    .rx_bit     (rx_bit),
    .destuff_en (destuff_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .stuff_drop (stuff_drop),
    .stuff_err  (stuff_err),
    .bit_cnt    (bit_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw bits of the current window; a position is a stuff slot when the
  // previous SL raw bits are all equal. A slot bit that repeats the run is a
  // violation and kills the frame until the window closes.
  bit   raw_q[$];
  bit   m_dead = 1'b0;
  bit   slot;
  logic e_dout = 1'b1, e_valid = 1'b0, e_drop = 1'b0, e_err = 1'b0;
  int   e_cnt = 0;

  always @(posedge clk) begin
    e_valid = 1'b0;
    e_drop  = 1'b0;
    if (rst) begin
      raw_q.delete(); m_dead = 1'b0; e_dout = 1'b1; e_err = 1'b0; e_cnt = 0;
    end else if (!destuff_en) begin
      raw_q.delete(); m_dead = 1'b0; e_err = 1'b0; e_cnt = 0;
    end else if (bit_strobe && !m_dead) begin
      slot = 1'b0;
      if (raw_q.size() >= SL) begin
        slot = 1'b1;
        for (int k = 1; k < SL; k++)
          if (raw_q[raw_q.size()-1-k] != raw_q[raw_q.size()-1]) slot = 1'b0;
      end
      if (slot && (rx_bit == raw_q[raw_q.size()-1])) begin
        m_dead = 1'b1; e_err = 1'b1;
      end else if (slot) begin
        e_drop = 1'b1;
      end else begin
        e_valid = 1'b1; e_dout = rx_bit;
        if (e_cnt < CNT_MAX) e_cnt++;
      end
      raw_q.push_back(rx_bit);
    end
  end

  // ---------------- compare process ----------------
  bit cap_q[$];
  int drop_n = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dout_valid", dout_valid, e_valid);
      chk("stuff_drop", stuff_drop, e_drop);
      chk("stuff_err", stuff_err, e_err);
      chk("bit_cnt", bit_cnt, e_cnt);
      chk("dout", dout, e_dout);
      if (dout_valid === 1'b1) cap_q.push_back(dout);
      if (stuff_drop === 1'b1) drop_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit s, input bit b, input bit en, input bit r);
    @(posedge clk);
    #3;
    bit_strobe = s; rx_bit = b; destuff_en = en; rst = r;
  endtask

  task automatic flush(input int n, input bit en);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, en, 1'b0);
  endtask

  task automatic new_frame();
    flush(2, 1'b0);
    flush(2, 1'b1);
    cap_q.delete();
    drop_n = 0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i], 1'b1, 1'b0);
  endtask

  function automatic logic [63:0] cap_packed();
    logic [63:0] p = '0;
    foreach (cap_q[i]) p = {p[62:0], cap_q[i]};
    return p;
  endfunction

  // Independent encoder: inserts a complement after every SL equal bits.
  bit gold_q[$];
  bit stream_q[$];
  task automatic build_stream(input int ndata);
    bit d, last;
    int run;
    gold_q.delete(); stream_q.delete();
    run = 0; last = 1'b1; d = 1'b0;
    for (int i = 0; i < ndata; i++) begin
      if ($urandom_range(2, 0) == 0) d = ~d;
      gold_q.push_back(d);
      stream_q.push_back(d);
      run = (run > 0 && d == last) ? run + 1 : 1;
      last = d;
      if (run == SL) begin
        stream_q.push_back(~d);
        last = ~d; run = 1;
      end
    end
  endtask

  function automatic logic [14:0] crc15(input bit q[$]);
    logic [14:0] c = '0;
    bit nx;
    foreach (q[i]) begin
      nx = q[i] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nx) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  int nbad;

  initial begin
    // reset state
    flush(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #3;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst dout", dout, 1'b1);
    chk("rst dout_valid", dout_valid, 1'b0);
    chk("rst stuff_drop", stuff_drop, 1'b0);
    chk("rst stuff_err", stuff_err, 1'b0);
    chk("rst bit_cnt", bit_cnt, 0);
    flush(1, 1'b0);

    // 0,0,0,0,0,stuff 1,0
    new_frame();
    send_bits(64'b0000010, 7);
    flush(2, 1'b1);
    chk("f1 deliveries", cap_q.size(), 6);
    chk("f1 data", cap_packed(), 0);
    chk("f1 drops", drop_n, 1);
    chk("f1 bit_cnt", bit_cnt, 6);
    chk("f1 stuff_err", stuff_err, 1'b0);

    // six equal bits -> violation, then silence until the window closes
    new_frame();
    send_bits(64'b000000, 6);
    flush(2, 1'b1);
    chk("f2 deliveries", cap_q.size(), 5);
    chk("f2 stuff_err", stuff_err, 1'b1);
    send_bits(64'b1010, 4);
    flush(2, 1'b1);
    chk("f2 deliveries after err", cap_q.size(), 5);
    chk("f2 drops", drop_n, 0);
    flush(2, 1'b0);
    chk("f2 stuff_err cleared", stuff_err, 1'b0);

    // stuff bit opens the next run
    new_frame();
    send_bits(64'b11111000001, 11);
    flush(2, 1'b1);
    chk("f3 drops", drop_n, 2);
    chk("f3 deliveries", cap_q.size(), 9);
    chk("f3 data", cap_packed(), 64'b111110000);

    // reset mid-run, coincident with a strobe
    new_frame();
    send_bits(64'b000, 3);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("midrst dout", dout, 1'b1);
    chk("midrst bit_cnt", bit_cnt, 0);
    chk("midrst dout_valid", dout_valid, 1'b0);
    cap_q.delete(); drop_n = 0;
    send_bits(64'b000001, 6);
    flush(2, 1'b1);
    chk("midrst new frame drops", drop_n, 1);
    chk("midrst new frame deliveries", cap_q.size(), 5);

    // window falls in the same cycle as a strobe
    new_frame();
    send_bits(64'b11, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    flush(2, 1'b0);
    chk("enfall deliveries", cap_q.size(), 2);
    chk("enfall bit_cnt", bit_cnt, 0);
    cap_q.delete(); drop_n = 0;
    flush(1, 1'b1);
    send_bits(64'b000001, 6);
    flush(2, 1'b1);
    chk("enfall restart drops", drop_n, 1);

    // back-to-back stuffed stream and downstream CRC
    new_frame();
    build_stream(34);
    foreach (stream_q[i]) drive(1'b1, stream_q[i], 1'b1, 1'b0);
    flush(2, 1'b1);
    chk("b2b length", cap_q.size(), gold_q.size());
    nbad = 0;
    foreach (gold_q[i]) if (i >= cap_q.size() || cap_q[i] != gold_q[i]) nbad++;
    chk("b2b data mismatches", nbad, 0);
    chk("b2b crc", crc15(cap_q), crc15(gold_q));
    chk("b2b stuff_err", stuff_err, 1'b0);

    // bit counter saturation
    new_frame();
    build_stream(300);
    foreach (stream_q[i]) drive(1'b1, stream_q[i], 1'b1, 1'b0);
    flush(2, 1'b1);
    chk("sat bit_cnt", bit_cnt, CNT_MAX);
    chk("sat deliveries", cap_q.size(), 300);

    // randomized soak against the model
    begin
      bit b = 1'b0;
      bit en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(2, 0) == 0) b = ~b;
        if ($urandom_range(99, 0) == 0) en = ~en;
        else if (!en && $urandom_range(3, 0) == 0) en = 1'b1;
        drive($urandom_range(1, 0) == 1, b, en, $urandom_range(399, 0) == 0);
      end
    end
    flush(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
